// File: rtl/kernel_ctrl_seq.sv
// Kernel-side sequencer: loads A then B in bursts, runs the array, and returns ap_done/ap_ready.
// Optional cycle counter output perf_cycles is built when KERNEL_CTRL_PERF_EN is defined.
module kernel_ctrl_seq #(
   parameter int BURST_BEATS     = 16,
   parameter int DATA_BYTES      = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int LEN_W           = $clog2(BURST_BEATS) + 1
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             ACLK_EN,
   input  logic             ap_start,
   input  logic [31:0]      scalar00,
   input  logic [63:0]      A,
   input  logic [63:0]      B,
   output logic             ap_done,
   output logic             ap_ready,
   output logic             ap_idle,
   output logic             ld_req_valid,
   input  logic             ld_req_ready,
   output logic [63:0]      ld_req_addr,
   output logic [LEN_W-1:0] ld_req_len,
   output logic             ld_req_sel,
   input  logic             ld_done,
   output logic             compute_start,
   input  logic             compute_done
`ifdef KERNEL_CTRL_PERF_EN
   ,
   output logic [31:0]      perf_cycles
`endif
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_A  = 3'd1;
   localparam logic [2:0] S_LOAD_B  = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_COMPUTE = 3'd4;
   localparam logic [2:0] S_WAIT_C  = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [31:0]      rem_q, rem_d;
   logic [63:0]      addr_q, addr_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic [63:0]      b_q, b_d;
   logic [31:0]      n_q, n_d;

   logic             in_load;
   logic             accept;
   logic             retire;
   logic [LEN_W-1:0] len_c;
   logic [31:0]      rem_next;
   logic [63:0]      addr_next;

   assign in_load   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign len_c     = (rem_q >= 32'(BURST_BEATS)) ? LEN_W'(BURST_BEATS) : rem_q[LEN_W-1:0];
   assign rem_next  = rem_q - 32'(len_c);
   assign addr_next = addr_q + (64'(len_c) * 64'(DATA_BYTES));

   assign ld_req_valid  = in_load && (out_q < OUT_W'(MAX_OUTSTANDING));
   assign ld_req_addr   = addr_q;
   assign ld_req_len    = len_c;
   assign ld_req_sel    = (state_q == S_LOAD_B);
   assign compute_start = (state_q == S_COMPUTE);
   assign ap_done       = (state_q == S_DONE);
   assign ap_ready      = (state_q == S_DONE);
   assign ap_idle       = (state_q == S_IDLE);

   // Everything is frozen while ACLK_EN is low, including acceptance of requests.
   assign accept = ACLK_EN && ld_req_valid && ld_req_ready;
   assign retire = ACLK_EN && ld_done && (out_q != '0);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      b_d     = b_q;
      n_d     = n_q;
      out_d   = out_q;
      if (accept && !retire)
         out_d = out_q + 1'b1;
      else if (retire && !accept)
         out_d = out_q - 1'b1;
      if (ACLK_EN) begin
         case (state_q)
            S_IDLE: begin
               if (ap_start) begin
                  b_d     = B;
                  n_d     = scalar00;
                  rem_d   = scalar00;
                  addr_d  = A;
                  state_d = (scalar00 == 32'd0) ? S_DONE : S_LOAD_A;
               end
            end
            S_LOAD_A, S_LOAD_B: begin
               if (accept) begin
                  rem_d  = rem_next;
                  addr_d = addr_next;
                  if (rem_next == 32'd0) begin
                     if (state_q == S_LOAD_A) begin
                        state_d = S_LOAD_B;
                        rem_d   = n_q;
                        addr_d  = b_q;
                     end else begin
                        state_d = S_DRAIN;
                     end
                  end
               end
            end
            // Look at the next count so the final ld_done moves on without an extra cycle.
            S_DRAIN:   if (out_d == '0) state_d = S_COMPUTE;
            S_COMPUTE: state_d = S_WAIT_C;
            S_WAIT_C:  if (compute_done) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         addr_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         out_q   <= out_d;
      end
   end

   always_ff @(posedge ACLK) begin
      b_q <= b_d;
      n_q <= n_d;
   end

`ifdef KERNEL_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   // Counts every enabled non-IDLE cycle of a run, DONE included.
   always_comb begin
      perf_d = perf_q;
      if (ACLK_EN) begin
         if (state_q == S_IDLE) begin
            if (ap_start) perf_d = '0;
         end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_kernel_ctrl_seq.sv
// Directed bench for kernel_ctrl_seq: BURST_BEATS=8, DATA_BYTES=4, MAX_OUTSTANDING=2.
module tb_kernel_ctrl_seq;
   localparam int BB = 8;
   localparam int DB = 4;
   localparam int MO = 2;
   localparam int LW = $clog2(BB) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic          ap_start = 1'b0;
   logic [31:0]   scalar00 = '0;
   logic [63:0]   A = '0;
   logic [63:0]   B = '0;
   logic          ap_done, ap_ready, ap_idle;
   logic          ld_req_valid;
   logic          ld_req_ready = 1'b0;
   logic [63:0]   ld_req_addr;
   logic [LW-1:0] ld_req_len;
   logic          ld_req_sel;
   logic          ld_done = 1'b0;
   logic          compute_start;
   logic          compute_done = 1'b0;
`ifdef KERNEL_CTRL_PERF_EN
   logic [31:0]   perf_cycles;
   logic [31:0]   perf1, perf2;
`endif

   kernel_ctrl_seq #(.BURST_BEATS(BB), .DATA_BYTES(DB), .MAX_OUTSTANDING(MO)) dut (
      .ACLK(clk), .ARESET(rst), .ACLK_EN(en), .ap_start(ap_start), .scalar00(scalar00),
      .A(A), .B(B), .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
      .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
      .ld_req_len(ld_req_len), .ld_req_sel(ld_req_sel), .ld_done(ld_done),
      .compute_start(compute_start), .compute_done(compute_done)
`ifdef KERNEL_CTRL_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc_n = 0;
   int          pending = 0;
   bit          auto_done = 1'b0;
   logic [63:0] q_addr[$];
   int          q_len[$];
   int          q_sel[$];

   logic [63:0] e_addr [6] = '{64'h1000, 64'h1020, 64'h1040, 64'h2000, 64'h2020, 64'h2040};
   int          e_len  [6] = '{8, 8, 4, 8, 8, 4};
   int          e_sel  [6] = '{0, 0, 0, 1, 1, 1};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // One clock: log any accept, advance past the edge, then the memory model answers.
   task automatic cyc();
      bit acc, dn;
      acc = ld_req_valid && ld_req_ready && en && !rst;
      dn  = ld_done && en;
      if (acc) begin
         q_addr.push_back(ld_req_addr);
         q_len.push_back(int'(ld_req_len));
         q_sel.push_back(int'(ld_req_sel));
      end
      @(posedge clk); #1;
      cyc_n++;
      if (acc) pending++;
      if (dn && pending > 0) pending--;
      ld_done = auto_done && (pending > 0);
   endtask

   task automatic wait_compute(input string tag);
      int last;
      bit seen;
      last = -100;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (compute_start) begin
            seen = 1'b1;
            break;
         end
         if (ld_done) last = cyc_n;
         cyc();
      end
      check({tag, "_cs_seen"}, 64'(seen), 64'd1);
      check({tag, "_cs_lat"}, 64'(cyc_n - last), 64'd1);
   endtask

   task automatic finish_run(input string tag);
      cyc();
      check({tag, "_cs_pulse"}, 64'(compute_start), 64'd0);
      cyc();
      compute_done = 1'b1;
      cyc();
      compute_done = 1'b0;
      check({tag, "_ap_done"}, 64'(ap_done), 64'd1);
      check({tag, "_ap_ready"}, 64'(ap_ready), 64'd1);
      cyc();
      check({tag, "_done_low"}, 64'(ap_done), 64'd0);
      check({tag, "_idle"}, 64'(ap_idle), 64'd1);
   endtask

   initial begin
      bit stable;
      bit seen;

      #1;
      check("rst_idle", 64'(ap_idle), 64'd1);
      check("rst_valid", 64'(ld_req_valid), 64'd0);
      check("rst_done", 64'(ap_done), 64'd0);
      check("rst_cs", 64'(compute_start), 64'd0);
      check("rst_addr", ld_req_addr, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Normal run, N=20
      A = 64'h1000; B = 64'h2000; scalar00 = 32'd20;
      ld_req_ready = 1'b1; auto_done = 1'b1;
      ap_start = 1'b1;
      cyc();
      ap_start = 1'b0;
      check("norm_first_valid", 64'(ld_req_valid), 64'd1);
      check("norm_first_addr", ld_req_addr, 64'h1000);
      check("norm_busy", 64'(ap_idle), 64'd0);
      wait_compute("norm");
      check("norm_req_count", 64'(q_addr.size()), 64'd6);
      for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
         check($sformatf("norm_addr%0d", i), q_addr[i], e_addr[i]);
         check($sformatf("norm_len%0d", i), 64'(q_len[i]), 64'(e_len[i]));
         check($sformatf("norm_sel%0d", i), 64'(q_sel[i]), 64'(e_sel[i]));
      end
      finish_run("norm");

      // N=0: straight to DONE
      scalar00 = 32'd0;
      ap_start = 1'b1;
      cyc();
      ap_start = 1'b0;
      check("zero_done", 64'(ap_done), 64'd1);
      check("zero_ready", 64'(ap_ready), 64'd1);
      check("zero_valid", 64'(ld_req_valid), 64'd0);
      check("zero_cs", 64'(compute_start), 64'd0);
      cyc();
      check("zero_idle", 64'(ap_idle), 64'd1);

      // Outstanding limit with ld_done withheld, N=64
      q_addr.delete(); q_len.delete(); q_sel.delete();
      auto_done = 1'b0;
      A = 64'h1000; B = 64'h3000; scalar00 = 32'd64;
      ap_start = 1'b1;
      cyc();
      ap_start = 1'b0;
      repeat (6) cyc();
      check("lim_accepts", 64'(q_addr.size()), 64'd2);
      check("lim_valid_low", 64'(ld_req_valid), 64'd0);
      ld_done = 1'b1;
      cyc();
      repeat (5) cyc();
      check("lim_one_more", 64'(q_addr.size()), 64'd3);
      check("lim_valid_low2", 64'(ld_req_valid), 64'd0);
      if (q_addr.size() > 2) check("lim_addr3", q_addr[2], 64'h1040);

      // Back-pressure: request held stable for 5 cycles
      ld_req_ready = 1'b0;
      ld_done = 1'b1;
      cyc();
      check("stall_valid", 64'(ld_req_valid), 64'd1);
      check("stall_addr", ld_req_addr, 64'h1060);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         stable &= ld_req_valid && (ld_req_addr == 64'h1060) && (ld_req_len == LW'(8)) && !ld_req_sel;
         cyc();
      end
      check("stall_hold", 64'(stable), 64'd1);

      // Same-cycle accept and ld_done keep the count at one
      ld_req_ready = 1'b1;
      ld_done = 1'b1;
      cyc();
      check("same_cycle_valid", 64'(ld_req_valid), 64'd1);
      cyc();
      check("same_cycle_full", 64'(ld_req_valid), 64'd0);
      check("same_cycle_count", 64'(q_addr.size()), 64'd5);

      // Async reset while in LOAD_B
      auto_done = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ld_req_valid && ld_req_sel) begin
            seen = 1'b1;
            break;
         end
         cyc();
      end
      check("reach_load_b", 64'(seen), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_idle", 64'(ap_idle), 64'd1);
      check("arst_valid", 64'(ld_req_valid), 64'd0);
      check("arst_sel", 64'(ld_req_sel), 64'd0);
      check("arst_addr", ld_req_addr, 64'd0);
      check("arst_len", 64'(ld_req_len), 64'd0);
      pending = 0; ld_done = 1'b0;
      q_addr.delete(); q_len.delete(); q_sel.delete();
      @(posedge clk); #1 rst = 1'b0;

      // Fresh run after reset, N=8, with a clock-enable hold
      A = 64'h5000; B = 64'h6000; scalar00 = 32'd8;
      ap_start = 1'b1;
      cyc();
      ap_start = 1'b0;
      check("post_rst_valid", 64'(ld_req_valid), 64'd1);
      check("post_rst_addr", ld_req_addr, 64'h5000);
      check("post_rst_len", 64'(ld_req_len), 64'd8);
      check("post_rst_sel", 64'(ld_req_sel), 64'd0);
      en = 1'b0;
      repeat (3) cyc();
      check("en_hold_addr", ld_req_addr, 64'h5000);
      check("en_hold_noacc", 64'(q_addr.size()), 64'd0);
      en = 1'b1;
      wait_compute("n8");
      check("n8_count", 64'(q_addr.size()), 64'd2);
      if (q_addr.size() > 1) begin
         check("n8_b_addr", q_addr[1], 64'h6000);
         check("n8_b_sel", 64'(q_sel[1]), 64'd1);
      end
      finish_run("n8");

      // Stray compute_done in IDLE is ignored
      compute_done = 1'b1;
      cyc();
      compute_done = 1'b0;
      check("stray_cd_done", 64'(ap_done), 64'd0);
      check("stray_cd_idle", 64'(ap_idle), 64'd1);

      // Auto-restart with ap_start held
      A = 64'h1000; B = 64'h2000; scalar00 = 32'd20;
      ap_start = 1'b1;
      cyc();
      wait_compute("b2b1");
      finish_run("b2b1");
`ifdef KERNEL_CTRL_PERF_EN
      perf1 = perf_cycles;
`endif
      cyc();
      check("b2b_restart_lat", 64'(ld_req_valid), 64'd1);
      ap_start = 1'b0;
      wait_compute("b2b2");
      finish_run("b2b2");
`ifdef KERNEL_CTRL_PERF_EN
      perf2 = perf_cycles;
      check("perf_equal", 64'(perf2), 64'(perf1));
      check("perf_nonzero", 64'(perf1 != 32'd0), 64'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
